// File: rtl/st2_branch_unit.sv
// st2_branch_unit: stage-2 (ID) branch resolution.
// Compares the comparator's relation code with the decoded branch type,
// computes the branch target and drives the PC select and IF/ID flush.
// It holds the front end (stall) while a branch operand is still in flight,
// and a watchdog flags hazard stalls that last too long.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   br_valid, br_type   branch present in IF/ID; 01 BLT, 10 BGT, 11 BEQ
//   cmp_result          comparator code: 01 lt, 10 gt, 11 eq
//   op_hazard           a branch operand is not yet forwardable
//   pc_plus2, br_offset branch address + 2, signed word offset
//   stall               combinational front-end freeze
//   pc_sel, flush       one-cycle redirect pulse (registered)
//   br_target           redirect address (registered)
//   hazard_err          sticky watchdog flag (registered)
// Optional: define ST2_BRANCH_STATS_EN to add taken_cnt / not_taken_cnt.
module st2_branch_unit #(
   parameter int unsigned STALL_MAX = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        br_valid,
   input  logic [1:0]  br_type,
   input  logic [1:0]  cmp_result,
   input  logic        op_hazard,
   input  logic [15:0] pc_plus2,
   input  logic [7:0]  br_offset,
   output logic        stall,
   output logic        pc_sel,
   output logic        flush,
   output logic [15:0] br_target,
   output logic        hazard_err
`ifdef ST2_BRANCH_STATS_EN
   ,
   output logic [15:0] taken_cnt,
   output logic [15:0] not_taken_cnt
`endif
);

   localparam int unsigned CNT_W = 4;
   localparam logic [CNT_W-1:0] STALL_LIM = CNT_W'(STALL_MAX);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_REDIRECT} state_t;

   state_t            state, state_nxt;
   logic [1:0]        cap_type, cap_type_nxt;
   logic [15:0]       cap_pc, cap_pc_nxt;
   logic [7:0]        cap_off, cap_off_nxt;
   logic [CNT_W-1:0]  stall_cnt, stall_cnt_nxt, cnt_inc;
   logic              pc_sel_nxt, flush_nxt, hazard_err_nxt;
   logic [15:0]       br_target_nxt, target_calc;
   logic              br_req, resolve, taken;
   logic [1:0]        res_type;
   logic [15:0]       res_pc;
   logic [7:0]        res_off;

   // Next-state, redirect decision and stall.
   always_comb begin
      state_nxt      = state;
      cap_type_nxt   = cap_type;
      cap_pc_nxt     = cap_pc;
      cap_off_nxt    = cap_off;
      stall_cnt_nxt  = stall_cnt;
      pc_sel_nxt     = 1'b0;
      flush_nxt      = 1'b0;
      br_target_nxt  = br_target;
      hazard_err_nxt = hazard_err;
      stall          = 1'b0;
      resolve        = 1'b0;
      br_req         = br_valid & (br_type != 2'b00);
      cnt_inc        = (stall_cnt == {CNT_W{1'b1}}) ? stall_cnt : stall_cnt + CNT_W'(1);

      // In WAIT the branch resolves from the captured fields, else from live ones.
      res_type    = (state == S_WAIT) ? cap_type : br_type;
      res_pc      = (state == S_WAIT) ? cap_pc   : pc_plus2;
      res_off     = (state == S_WAIT) ? cap_off  : br_offset;
      taken       = (cmp_result == res_type);
      target_calc = res_pc + {{7{res_off[7]}}, res_off, 1'b0};

      case (state)
         S_IDLE: begin
            if (br_req) begin
               if (op_hazard) begin
                  stall         = 1'b1;
                  cap_type_nxt  = br_type;
                  cap_pc_nxt    = pc_plus2;
                  cap_off_nxt   = br_offset;
                  stall_cnt_nxt = CNT_W'(1);
                  if (STALL_LIM <= CNT_W'(1)) hazard_err_nxt = 1'b1;
                  state_nxt     = S_WAIT;
               end else begin
                  resolve = 1'b1;
               end
            end
         end
         S_WAIT: begin
            if (op_hazard) begin
               stall         = 1'b1;
               stall_cnt_nxt = cnt_inc;
               if (cnt_inc >= STALL_LIM) hazard_err_nxt = 1'b1;
            end else begin
               resolve       = 1'b1;
               stall_cnt_nxt = '0;
            end
         end
         // Instruction in IF/ID is being flushed; br_valid is ignored.
         S_REDIRECT: state_nxt = S_IDLE;
         default:    state_nxt = S_IDLE;
      endcase

      if (resolve) begin
         if (taken) begin
            state_nxt     = S_REDIRECT;
            pc_sel_nxt    = 1'b1;
            flush_nxt     = 1'b1;
            br_target_nxt = target_calc;
         end else begin
            state_nxt = S_IDLE;
         end
      end
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         cap_type   <= 2'b00;
         cap_pc     <= 16'h0000;
         cap_off    <= 8'h00;
         stall_cnt  <= '0;
         pc_sel     <= 1'b0;
         flush      <= 1'b0;
         br_target  <= 16'h0000;
         hazard_err <= 1'b0;
      end else begin
         state      <= state_nxt;
         cap_type   <= cap_type_nxt;
         cap_pc     <= cap_pc_nxt;
         cap_off    <= cap_off_nxt;
         stall_cnt  <= stall_cnt_nxt;
         pc_sel     <= pc_sel_nxt;
         flush      <= flush_nxt;
         br_target  <= br_target_nxt;
         hazard_err <= hazard_err_nxt;
      end
   end

`ifdef ST2_BRANCH_STATS_EN
   // Saturating resolution statistics.
   always_ff @(posedge clk) begin
      if (rst) begin
         taken_cnt     <= 16'h0000;
         not_taken_cnt <= 16'h0000;
      end else if (resolve) begin
         if (taken) begin
            if (taken_cnt != 16'hFFFF) taken_cnt <= taken_cnt + 16'd1;
         end else begin
            if (not_taken_cnt != 16'hFFFF) not_taken_cnt <= not_taken_cnt + 16'd1;
         end
      end
   end
`endif

endmodule

// File: doc/st2_branch_unit.md
# st2_branch_unit

Stage-2 (ID) branch resolution unit, directly downstream of the stage-2 operand comparator. Consumes the comparator's 2-bit relation code together with the decoded branch type. Decides taken/not-taken, computes the branch target, and drives the PC-select and IF/ID flush. Stalls the front end while a branch operand is still in flight in EX/MEM, with a watchdog on stall length.

## Interface

Parameters:
- `STALL_MAX`, default 3: maximum consecutive hazard-stall cycles before `hazard_err` is set (1..15).

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `br_valid` in 1: IF/ID holds a branch instruction.
- `br_type` in 2: 01 BLT, 10 BGT, 11 BEQ, 00 not a branch.
- `cmp_result` in 2: comparator code; 01 less-than, 10 greater-than, 11 equal.
- `op_hazard` in 1: a branch operand (op1 or reg15) is not yet available via forwarding.
- `pc_plus2` in 16: address of the branch plus 2.
- `br_offset` in 8: signed word offset.
- `stall` out 1: freeze PC and IF/ID (combinational).
- `pc_sel` out 1: 1 = PC loads `br_target` (registered).
- `flush` out 1: clear IF/ID (registered).
- `br_target` out 16: branch target address (registered).
- `hazard_err` out 1: sticky watchdog error (registered).

## Operation

- **Branch qualification:** `br_req = br_valid & (br_type != 2'b00)`.
- **Taken rule:** `taken = (cmp_result == br_type)`, evaluated only when resolving.
- **Target:** `pc_plus2 + {{7{br_offset[7]}}, br_offset, 1'b0}`.
  - Modulo 2^16; wrap-around is silent.
- **States:** IDLE, WAIT, REDIRECT.
- **IDLE:**
  - `br_req & op_hazard`: capture `br_type`, `pc_plus2` and `br_offset`; load the stall counter with 1; go to WAIT.
  - `br_req & !op_hazard & taken`: register the target; go to REDIRECT.
  - `br_req & !op_hazard & !taken`: stay in IDLE; no pulse.
  - No request: stay in IDLE.
- **WAIT:** resolves using the captured type and offset and the live `cmp_result`.
  - `op_hazard=0`: resolve as in IDLE (taken goes to REDIRECT, not-taken goes to IDLE).
  - `op_hazard=1`: increment the counter.
    - If the counter reaches `STALL_MAX`, set `hazard_err` and remain in WAIT.
    - The counter saturates.
- **REDIRECT:** `pc_sel=1` and `flush=1` for exactly this one cycle.
  - `br_valid` is ignored, because that instruction is being flushed.
  - Next state is IDLE.
- **Stall:** `stall = (IDLE & br_req & op_hazard) | (WAIT & op_hazard)`.
- **Reset values:**
  - State is IDLE.
  - `pc_sel`, `flush` and `hazard_err` are 0.
  - `br_target` is 16'h0000.
  - The stall counter is 0.
- **Reset during operation:** reset in WAIT or REDIRECT abandons the branch. No redirect is issued, and all outputs read their reset values in the next cycle.

## Timing

- **Taken, no hazard:** branch presented in cycle T; `pc_sel`, `flush` and `br_target` are valid in T+1 only.
- **Not-taken, no hazard:** zero penalty; outputs stay 0.
- **Hazard:**
  - `stall` is high in the same cycle T as `op_hazard`.
  - Resolution happens in the first cycle with `op_hazard=0`; the redirect follows one cycle later.
- **Back-to-back branches:** a branch in IDLE immediately after REDIRECT is processed normally.
- **Watchdog timing:** with `STALL_MAX`=3, `hazard_err` rises on the edge that ends the 3rd consecutive stall cycle.
- **Ordering:** `stall` and `pc_sel` are never high in the same cycle.

## Configuration

- **Macro:** `ST2_BRANCH_STATS_EN`.
- **When defined, adds output ports:**
  - `taken_cnt` out 16: count of resolved taken branches.
  - `not_taken_cnt` out 16: count of resolved not-taken branches.
- **Counter behaviour:**
  - Each counter increments once per resolution and saturates at 16'hFFFF.
  - Both counters reset to 0.
- **When undefined:** the ports and counters are absent; all other behaviour is identical.

## Test plan

- **Taken BEQ:** `br_type`=11, `cmp_result`=11, `pc_plus2`=16'h0040, `br_offset`=8'h05, no hazard. Expect `pc_sel`=`flush`=1 for one cycle, with `br_target`=16'h004A.
- **Not-taken BLT:** `br_type`=01, `cmp_result`=10. Expect no `pc_sel`/`flush` pulse and `stall`=0 throughout.
- **Backward branch:** BGT with `br_offset`=8'hFE at `pc_plus2`=16'h0002. Expect `br_target`=16'hFFFE (wrap-around), taken when `cmp_result`=10.
- **Hazard recovery:** BEQ with `op_hazard`=1 for 2 cycles, then 0 with `cmp_result`=11.
  - Expect `stall`=1 for 2 cycles, then a redirect pulse one cycle after resolution.
  - Expect `hazard_err`=0.
- **Watchdog and reset:**
  - Hold `op_hazard`=1 for 4 cycles; expect `hazard_err`=1 after the 3rd.
  - Then assert `rst` in WAIT; expect state IDLE, `hazard_err`=0 and no redirect.
- **Stats:** with `ST2_BRANCH_STATS_EN`, run 3 taken and 2 not-taken branches. Expect `taken_cnt`=3 and `not_taken_cnt`=2.
